// File: rtl/rm_sched_pkg.sv
// rtl/rm_sched_pkg.sv - shared types for the reference-model step scheduler
package rm_sched_pkg;

    localparam int RM_CAUSE_W = 11;

    typedef enum logic {
        CMD_STEP = 1'b0,
        CMD_INTR = 1'b1
    } rm_cmd_e;

    typedef struct packed {
        logic [63:0]           order;
        logic                  intr;
        logic [RM_CAUSE_W-1:0] cause;
    } rm_retire_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INTR_CMD,
        ST_STEP_CMD,
        ST_WAIT
    } rm_state_e;

endpackage

// File: rtl/rm_retire_fifo.sv
// rtl/rm_retire_fifo.sv - NRET-write, single-read circular buffer of retire events
module rm_retire_fifo
    import rm_sched_pkg::*;
#(
    parameter int NRET  = 1,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [CNT_W-1:0]       wr_cnt,
    input  rm_retire_t [NRET-1:0]  wr_data,
    input  logic                   rd_en,
    output rm_retire_t             rd_data,
    output logic [CNT_W-1:0]       count
);

    localparam int PTR_W = $clog2(DEPTH);

    rm_retire_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // wr_data is already compacted: slots 0..wr_cnt-1 are the entries to store
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < NRET; i++) begin
                if (CNT_W'(i) < wr_cnt) begin
                    mem[wr_ptr + PTR_W'(i)] <= wr_data[i];
                end
            end
            wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + wr_cnt - CNT_W'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/rm_step_scheduler.sv
// rtl/rm_step_scheduler.sv - buffers DUT retirements and steps the ISS one instruction at a time
module rm_step_scheduler
    import rm_sched_pkg::*;
#(
    parameter int NRET    = 1,
    parameter int DEPTH   = 8,
    parameter int CAUSE_W = 11
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NRET-1:0]             retire_valid_i,
    input  logic [NRET*64-1:0]          retire_order_i,
    input  logic [NRET-1:0]             retire_intr_i,
    input  logic [NRET*CAUSE_W-1:0]     retire_cause_i,
    output logic                        iss_cmd_valid_o,
    output logic                        iss_cmd_o,
    output logic [CAUSE_W-1:0]          iss_cmd_cause_o,
    input  logic                        iss_cmd_ready_i,
    input  logic                        iss_done_i,
    output logic                        cmp_valid_o,
    output logic [63:0]                 cmp_order_o,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy_o,
    output logic                        overflow_o,
    output logic                        order_err_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    rm_state_e             state, state_next;
    rm_cmd_e               cmd;
    rm_retire_t [NRET-1:0] wr_data;
    rm_retire_t            head;
    logic [CNT_W-1:0]      lane_cnt, wr_cnt, count, free;
    logic [63:0]           exp_order, exp_next;
    logic                  accept, drop, err_seen, pop;

    always_comb begin
        int n;
        n       = 0;
        wr_data = '0;
        for (int i = 0; i < NRET; i++) begin
            if (retire_valid_i[i]) begin
                for (int j = 0; j < NRET; j++) begin
                    if (j == n) begin
                        wr_data[j] = {retire_order_i[i*64 +: 64], retire_intr_i[i],
                                      RM_CAUSE_W'(retire_cause_i[i*CAUSE_W +: CAUSE_W])};
                    end
                end
                n = n + 1;
            end
        end
        lane_cnt = CNT_W'(n);
    end

    // A pop this cycle does not make room; a cycle that does not fit is dropped whole
    assign free   = CNT_W'(DEPTH) - count;
    assign accept = (lane_cnt <= free);
    assign drop   = (lane_cnt != '0) && !accept;
    assign wr_cnt = accept ? lane_cnt : '0;

    always_comb begin
        exp_next = exp_order;
        err_seen = 1'b0;
        for (int j = 0; j < NRET; j++) begin
            if (CNT_W'(j) < wr_cnt) begin
                if (wr_data[j].order != exp_next) begin
                    err_seen = 1'b1;
                end
                exp_next = wr_data[j].order + 64'd1;
            end
        end
    end

    rm_retire_fifo #(
        .NRET  (NRET),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_cnt  (wr_cnt),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count)
    );

    always_comb begin
        state_next      = state;
        iss_cmd_valid_o = 1'b0;
        cmd             = CMD_STEP;
        iss_cmd_cause_o = '0;
        pop             = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    state_next = head.intr ? ST_INTR_CMD : ST_STEP_CMD;
                end
            end
            ST_INTR_CMD: begin
                iss_cmd_valid_o = 1'b1;
                cmd             = CMD_INTR;
                iss_cmd_cause_o = CAUSE_W'(head.cause);
                if (iss_cmd_ready_i) begin
                    state_next = ST_STEP_CMD;
                end
            end
            ST_STEP_CMD: begin
                iss_cmd_valid_o = 1'b1;
                if (iss_cmd_ready_i) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (iss_done_i) begin
                    pop        = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign iss_cmd_o   = cmd;
    assign occupancy_o = count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            exp_order   <= '0;
            overflow_o  <= 1'b0;
            order_err_o <= 1'b0;
            cmp_valid_o <= 1'b0;
            cmp_order_o <= '0;
        end else begin
            state       <= state_next;
            exp_order   <= exp_next;
            overflow_o  <= overflow_o | drop;
            order_err_o <= order_err_o | err_seen;
            cmp_valid_o <= pop;
            if (pop) begin
                cmp_order_o <= head.order;
            end
        end
    end

endmodule
